// File: rtl/program_ram_pkg.sv
// Shared types and sizing for the program_ram unified program/data memory.
package program_ram_pkg;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The final slot ends a load even without load_last, so the pointer never wraps.
    function automatic logic is_last_slot(input logic [ADDR_W-1:0] ptr);
        return ptr == ADDR_W'(DEPTH - 1);
    endfunction

endpackage

// File: rtl/ram_array_16x8.sv
// 16x8 storage: asynchronous read, synchronous single-port write, cleared by reset.
module ram_array_16x8
    import program_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: every word is cleared on reset because a mid-load reset must leave no
    // stale program behind; this keeps the array in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_ram.sv
// Program/data RAM with a post-reset byte-stream loader that holds the CPU until loading ends.
// Optional write protection of the loaded region: define PROGRAM_RAM_WRPROT_EN.
module program_ram
    import program_ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_address,
    input  logic              ram_read_en,
    input  logic              ram_write_en,
    inout  wire  [WIDTH-1:0]  ram_data,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    input  logic              load_start,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [CNT_W-1:0]  load_count,
    output logic              wr_fault
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              fault, fault_nxt;

    logic              cpu_wr;
    logic              wr_blocked;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  rd_data;

    assign cpu_wr = (state == RUN) && ram_write_en;

`ifdef PROGRAM_RAM_WRPROT_EN
    assign wr_blocked = cpu_wr && ({1'b0, ram_address} < count);
`else
    assign wr_blocked = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            ptr   <= '0;
            count <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            count <= count_nxt;
            fault <= fault_nxt;
        end
    end

    // NOTE: all outputs of this block get a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        count_nxt = count;
        fault_nxt = fault;
        case (state)
            LOAD: begin
                if (load_valid) begin
                    count_nxt = count + CNT_W'(1);
                    if (load_last || is_last_slot(ptr)) begin
                        state_nxt = RUN;
                    end else begin
                        ptr_nxt = ptr + ADDR_W'(1);
                    end
                end
            end
            RUN: begin
                if (wr_blocked) begin
                    fault_nxt = 1'b1;
                end
                // A write in the same cycle still lands; only the bookkeeping restarts.
                if (load_start) begin
                    state_nxt = LOAD;
                    ptr_nxt   = '0;
                    count_nxt = '0;
                    fault_nxt = 1'b0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Single write port: the loader owns it in LOAD, the CPU in RUN.
    always_comb begin
        if (state == LOAD) begin
            mem_we    = load_valid;
            mem_addr  = ptr;
            mem_wdata = load_data;
        end else begin
            mem_we    = cpu_wr && !wr_blocked;
            mem_addr  = ram_address;
            mem_wdata = ram_data;
        end
    end

    ram_array_16x8 u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .wr_addr (mem_addr),
        .wr_data (mem_wdata),
        .rd_addr (ram_address),
        .rd_data (rd_data)
    );

    // Write enable wins over read enable, so the CPU and this block never both drive.
    assign ram_data = (state == RUN && ram_read_en && !ram_write_en) ? rd_data : 'z;

    assign load_ready = (state == LOAD);
    assign cpu_hold   = (state == LOAD);
    assign load_done  = (state == RUN);
    assign load_count = count;
    assign wr_fault   = fault;

endmodule

// File: tb/tb_program_ram.sv
// Bench for program_ram: directed loader/CPU scenarios plus random CPU traffic against an array model.
module tb_program_ram;
    import program_ram_pkg::*;

`ifdef PROGRAM_RAM_WRPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read_en;
    logic              ram_write_en;
    wire  [WIDTH-1:0]  ram_data;
    logic [WIDTH-1:0]  bus_val;
    logic              bus_drv;
    logic              load_valid;
    logic [WIDTH-1:0]  load_data;
    logic              load_last;
    logic              load_start;
    logic              load_ready;
    logic              cpu_hold;
    logic              load_done;
    logic [CNT_W-1:0]  load_count;
    logic              wr_fault;

    assign ram_data = bus_drv ? bus_val : 'z;

    always #5 clk = ~clk;

    program_ram dut (
        .clk          (clk),
        .rst          (rst),
        .ram_address  (ram_address),
        .ram_read_en  (ram_read_en),
        .ram_write_en (ram_write_en),
        .ram_data     (ram_data),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_start   (load_start),
        .load_ready   (load_ready),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_count   (load_count),
        .wr_fault     (wr_fault)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the memory as a plain array plus loader bookkeeping.
    logic [7:0] m_mem [16];
    bit         m_run;
    int         m_ptr;
    int         m_count;
    bit         m_fault;

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_run   = 1'b0;
        m_ptr   = 0;
        m_count = 0;
        m_fault = 1'b0;
    endtask

    // Applies one rising edge's worth of behaviour using the inputs currently driven.
    task automatic model_edge();
        if (!m_run) begin
            if (load_valid) begin
                m_mem[m_ptr] = load_data;
                m_count++;
                if (load_last || m_count == 16) m_run = 1'b1;
                else m_ptr++;
            end
        end else begin
            if (ram_write_en) begin
                if (PROT && int'(ram_address) < m_count) m_fault = 1'b1;
                else m_mem[ram_address] = bus_val;
            end
            if (load_start) begin
                m_run   = 1'b0;
                m_ptr   = 0;
                m_count = 0;
                m_fault = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // An undriven bus reads as z in a four-state simulator and as 0 in a two-state one.
    task automatic check_hiz(input string tag);
        total++;
        assert (ram_data === 8'hzz || ram_data === 8'h00)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=high-Z", tag, ram_data);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".ready"}, 8'(load_ready), 8'(!m_run));
        check({tag, ".hold"},  8'(cpu_hold),   8'(!m_run));
        check({tag, ".done"},  8'(load_done),  8'(m_run));
        check({tag, ".count"}, 8'(load_count), 8'(m_count));
        check({tag, ".fault"}, 8'(wr_fault),   8'(m_fault));
    endtask

    task automatic read_check(input logic [3:0] a, input string tag);
        @(negedge clk);
        ram_address  = a;
        ram_read_en  = 1'b1;
        ram_write_en = 1'b0;
        bus_drv      = 1'b0;
        #1;
        if (m_run) check(tag, ram_data, m_mem[a]);
        else check_hiz(tag);
        ram_read_en = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) read_check(4'(a), $sformatf("%s[%0d]", tag, a));
    endtask

    task automatic step(input bit we, input logic [3:0] a, input logic [7:0] d,
                        input bit start, input string tag);
        @(negedge clk);
        ram_write_en = we;
        ram_read_en  = 1'($urandom_range(0, 1));
        ram_address  = a;
        bus_val      = d;
        bus_drv      = we;
        load_start   = start;
        model_edge();
        @(posedge clk);
        #1;
        ram_write_en = 1'b0;
        ram_read_en  = 1'b0;
        bus_drv      = 1'b0;
        load_start   = 1'b0;
        check_status(tag);
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last, input bit start, input string tag);
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        load_start = start;
        model_edge();
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = 1'b0;
        check_status(tag);
    endtask

    logic [7:0] prog [4];
    logic [3:0] ra;

    initial begin
        prog = '{8'h21, 8'h12, 8'h80, 8'h00};
        rst = 1'b0;
        ram_address = '0;
        ram_read_en = 1'b0;
        ram_write_en = 1'b0;
        bus_val = '0;
        bus_drv = 1'b0;
        load_valid = 1'b0;
        load_data = '0;
        load_last = 1'b0;
        load_start = 1'b0;
        model_reset();

        #3;
        check_status("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Four-byte program ended by load_last.
        for (int i = 0; i < 4; i++) load_byte(prog[i], i == 3, 1'b0, $sformatf("ld4_%0d", i));
        read_all("ld4_rd");

        // CPU write then read-back, and an undriven bus with read_en low.
        step(1'b1, 4'hE, 8'h5A, 1'b0, "wr_e");
        read_check(4'hE, "rd_e");
        @(negedge clk);
        ram_address = 4'h0;
        ram_read_en = 1'b0;
        #1;
        check_hiz("idle_bus");

        // Writes inside and outside the loaded region.
        step(1'b1, 4'h2, 8'hFF, 1'b0, "wp_2");
        read_check(4'h2, "wp_rd2");
        step(1'b1, 4'h9, 8'h3C, 1'b0, "wp_9");
        read_check(4'h9, "wp_rd9");

        // Random CPU traffic while 4 bytes are loaded.
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) step(1'b1, ra, 8'($urandom), 1'b0, $sformatf("rnd1_w%0d", i));
            else read_check(ra, $sformatf("rnd1_r%0d", i));
        end

        // Reload: a write coinciding with load_start still lands; old mem[5] must survive.
        step(1'b1, 4'h5, 8'h77, 1'b0, "pre5");
        step(1'b1, 4'hB, 8'h66, 1'b1, "wr_start");
        read_check(4'h0, "load_bus");
        load_byte(8'($urandom), 1'b0, 1'b1, "rl_0");
        load_byte(8'($urandom), 1'b1, 1'b0, "rl_1");
        read_all("rl_rd");

        // load_valid is refused while in RUN.
        repeat (3) load_byte(8'hA5, 1'b1, 1'b0, "rv_ign");
        read_all("rv_rd");

        for (int i = 0; i < 16; i++) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) step(1'b1, ra, 8'($urandom), 1'b0, $sformatf("rnd2_w%0d", i));
            else read_check(ra, $sformatf("rnd2_r%0d", i));
        end

        // Full 16-byte load without load_last, then extra bytes must not wrap onto mem[15].
        step(1'b0, 4'h0, 8'h00, 1'b1, "fl_start");
        for (int i = 0; i < 16; i++) load_byte(8'($urandom), 1'b0, 1'b0, $sformatf("fl_%0d", i));
        repeat (3) load_byte(8'hC3, 1'b0, 1'b0, "fl_extra");
        read_all("fl_rd");
        step(1'b1, 4'h3, 8'h99, 1'b0, "fl_wr3");
        read_check(4'h3, "fl_rd3");

        // Asynchronous reset in the middle of a load.
        step(1'b0, 4'h0, 8'h00, 1'b1, "mr_start");
        for (int i = 0; i < 3; i++) load_byte(8'($urandom_range(1, 255)), 1'b0, 1'b0, $sformatf("mr_%0d", i));
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_status("mr_async");
        @(negedge clk);
        rst = 1'b1;
        load_byte(8'h42, 1'b1, 1'b0, "mr_ld");
        read_all("mr_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_ram.md
# program_ram

Unified 16×8 program/data memory for the 8-bit CPU, sitting directly downstream of the control unit on its `ram_address` / `ram_data` / `ram_read_en` / `ram_write_en` bus.

- Built-in loader FSM accepts a program byte stream over a valid/ready port after reset.
- While loading, the CPU is held via `cpu_hold`, which drives the control unit's `rst`.
- After loading, the block serves combinational instruction/operand reads and clocked STORE_A writes.

## Interface
- `WIDTH`, 8 — data word width.
- `ADDR_W`, 4 — address width.
- `DEPTH`, 16 — number of words, equal to 2**ADDR_W.

- `clk`  in  1  — the single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `ram_address`  in  ADDR_W  — CPU address.
- `ram_read_en`  in  1  — CPU read enable.
- `ram_write_en`  in  1  — CPU write enable; the CPU drives `ram_data` while this is high.
- `ram_data`  inout  WIDTH  — shared data bus.
- `load_valid`  in  1  — a loader byte is present.
- `load_data`  in  WIDTH  — loader byte.
- `load_last`  in  1  — marks the final byte of the program.
- `load_start`  in  1  — single-cycle request to reload, honoured only in RUN.
- `load_ready`  out  1  — loader can accept a byte.
- `cpu_hold`  out  1  — active-high hold, connected to the control unit's `rst`.
- `load_done`  out  1  — high while in RUN.
- `load_count`  out  ADDR_W+1  — number of bytes accepted in the last load (0..16).
- `wr_fault`  out  1  — sticky write-protect violation; see Configuration.

## Operation
- **States:** LOAD and RUN.
- **Reset (`rst`=0):**
  - state = LOAD, load pointer = 0, `load_count` = 0.
  - All memory words = 0.
  - `load_ready` = 1, `cpu_hold` = 1, `load_done` = 0, `wr_fault` = 0.
  - `ram_data` = high-Z.
- **LOAD:**
  - A byte is accepted when `load_valid` and `load_ready` are both high at a rising edge: mem[ptr] ← `load_data`, then ptr and `load_count` increment.
  - Go to RUN when the accepted byte has `load_last`=1 or ptr = DEPTH-1.
  - CPU reads and writes are ignored; `ram_data` stays high-Z.
  - `load_start` is ignored.
- **RUN:**
  - `load_ready` = 0, `cpu_hold` = 0, `load_done` = 1.
  - Read: when `ram_read_en`=1 and `ram_write_en`=0, `ram_data` = mem[`ram_address`] combinationally. Otherwise the block does not drive the bus.
  - Write: when `ram_write_en`=1 at a rising edge, mem[`ram_address`] ← `ram_data`.
  - `load_start`=1 at a rising edge moves the block to LOAD:
    - ptr = 0 and `load_count` = 0.
    - Memory contents are retained, and bytes are overwritten as they arrive.
    - `wr_fault` is cleared.
- **Simultaneous events:**
  - CPU write and `load_start` in the same cycle: the write completes, then the block enters LOAD.
  - `load_valid` while `load_ready`=0: the byte is not accepted; nothing changes.
  - `ram_read_en` and `ram_write_en` both high: this is a write; the block never drives the bus, so there is no contention.
- **Pointer:** saturates at DEPTH-1; it never wraps into a 17th write.

## Timing
- Read latency is 0 cycles, combinational from `ram_address`. This matches the control unit, which sets the address at one edge and samples `ram_data` at the next.
- Write latency is 1 edge; the new value is readable in the following cycle.
- LOAD→RUN happens at the edge that accepts the last byte. `cpu_hold` falls and `load_done` rises in the next cycle; `load_ready` falls in that same cycle.
- RUN→LOAD happens at the edge sampling `load_start`. `cpu_hold` and `load_ready` rise in the next cycle.
- All outputs except `ram_data` are registered or state-decoded; there are no combinational paths from loader inputs to outputs.
- Reset asserted mid-load or mid-run takes effect immediately (asynchronous), with all values as listed for reset.

## Configuration
- Macro: `PROGRAM_RAM_WRPROT_EN`.
- **Defined:** in RUN, a CPU write to an address below `load_count` is dropped (memory unchanged) and sets `wr_fault`=1. `wr_fault` stays set until reset or `load_start`. Writes at or above `load_count` proceed normally.
- **Undefined:** all CPU writes proceed and `wr_fault` is tied to 0.

## Structure
- Package `program_ram_pkg`:
  - state enum {LOAD, RUN};
  - `WIDTH`, `ADDR_W` and `DEPTH` constants;
  - `load_count` width.
- Sub-module `ram_array_16x8`:
  - storage with asynchronous read and synchronous single-port write;
  - reset clears all words;
  - the write port is muxed between loader and CPU in the top level by state.
- The top level holds the FSM, pointer, handshake, tri-state driver and write-protect logic.

## Test plan
- **Reset load:** stream 0x21, 0x12, 0x80, 0x00 with `load_last` on the 4th byte → `load_count`=4; `cpu_hold` falls the cycle after the 4th accept; reads of addresses 0..3 in RUN return the same bytes.
- **Full load:** 16 bytes with no `load_last` → RUN after the 16th byte; `load_valid` held high afterwards is not accepted and mem[15] is unchanged.
- **CPU write/read:** in RUN, write 0x5A to address 0xE → a read of 0xE the next cycle returns 0x5A; with `ram_read_en`=0 the bus is high-Z.
- **Write protect (`PROGRAM_RAM_WRPROT_EN` defined):** `load_count`=4, write 0xFF to address 2 → mem[2] unchanged and `wr_fault`=1; a write to address 9 succeeds.
- **Reload:** pulse `load_start` in RUN → `cpu_hold`=1 next cycle and `wr_fault` cleared; load 2 bytes → `load_count`=2 and old mem[5] is retained.
- **Mid-load reset:** assert `rst`=0 after 3 bytes → all memory 0, ptr 0, `load_ready`=1 immediately.
